// File: rtl/p_stage_accum_20bits_if.sv
// Bus between the SIMD ALU and its P output stage.
// Carries the ALU result, detect controls and the registered P-stage outputs.
interface p_stage_accum_20bits_if #(
    parameter int Width = 20
);
    logic             CEP;
    logic             RSTP;
    logic             valid_in;
    logic [1:0]       USE_SIMD;
    logic [Width-1:0] S;
    logic [1:0]       result_SIDM_carry_out;
    logic [Width-1:0] PATTERN;
    logic [Width-1:0] MASK;

    logic [Width-1:0] P;
    logic             valid_out;
    logic [1:0]       CARRYOUT;
    logic [1:0]       PATTERNDETECT;
    logic [1:0]       PATTERNBDETECT;
    logic [1:0]       OVERFLOW;
    logic [1:0]       UNDERFLOW;
    logic [1:0]       OVF_STICKY;

    modport master (
        output CEP, RSTP, valid_in, USE_SIMD, S, result_SIDM_carry_out, PATTERN, MASK,
        input  P, valid_out, CARRYOUT, PATTERNDETECT, PATTERNBDETECT,
               OVERFLOW, UNDERFLOW, OVF_STICKY
    );

    modport slave (
        input  CEP, RSTP, valid_in, USE_SIMD, S, result_SIDM_carry_out, PATTERN, MASK,
        output P, valid_out, CARRYOUT, PATTERNDETECT, PATTERNBDETECT,
               OVERFLOW, UNDERFLOW, OVF_STICKY
    );
endinterface

// File: rtl/p_stage_accum_20bits.sv
// P register stage behind the 20-bit SIMD ALU: captures S and carries, runs per-lane
// pattern detection, and derives overflow/underflow from the current vs previous detect.
module p_stage_accum_20bits #(
    parameter int Width     = 20,
    parameter int Seg0Width = 14
) (
    input logic                   clk,
    input logic                   rstn,
    p_stage_accum_20bits_if.slave bus
);

    logic [Width-1:0] p_p0;
    logic             vld_p0;
    logic [1:0]       carry_p0;
    logic [1:0]       pd_p0;
    logic [1:0]       pbd_p0;
    logic [1:0]       pd_past_p0;
    logic [1:0]       pbd_past_p0;
    logic [1:0]       sticky_p0;

    logic             load;
    logic [1:0]       pd_next;
    logic [1:0]       pbd_next;
    logic [1:0]       ovf;
    logic [1:0]       unf;

    // Per-lane masked compare; single-lane modes replicate the full-width result.
    function automatic logic [1:0] lane_detect(
        input logic [Width-1:0] s,
        input logic [Width-1:0] pat,
        input logic [Width-1:0] mask,
        input logic [1:0]       simd
    );
        logic [Width-1:0] m;
        logic             seg0;
        logic             seg1;
        m    = ~(s ^ pat) | mask;
        seg0 = &m[Seg0Width-1:0];
        seg1 = &m[Width-1:Seg0Width];
        if (simd == 2'b10) begin
            return {seg1, seg0};
        end
        return {seg0 & seg1, seg0 & seg1};
    endfunction

    assign load     = bus.CEP & bus.valid_in & ~bus.RSTP;
    assign pd_next  = lane_detect(bus.S, bus.PATTERN, bus.MASK, bus.USE_SIMD);
    assign pbd_next = lane_detect(bus.S, ~bus.PATTERN, bus.MASK, bus.USE_SIMD);

    // Event flags are decoded from registered state so they line up with P.
    assign ovf = pd_past_p0  & ~pd_p0 & ~pbd_p0;
    assign unf = pbd_past_p0 & ~pd_p0 & ~pbd_p0;

    // ---- stage p0: P register and detect history ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_p0        <= '0;
            vld_p0      <= 1'b0;
            carry_p0    <= '0;
            pd_p0       <= '0;
            pbd_p0      <= '0;
            pd_past_p0  <= '0;
            pbd_past_p0 <= '0;
            sticky_p0   <= '0;
        end else if (bus.RSTP) begin
            p_p0        <= '0;
            vld_p0      <= 1'b0;
            carry_p0    <= '0;
            pd_p0       <= '0;
            pbd_p0      <= '0;
            pd_past_p0  <= '0;
            pbd_past_p0 <= '0;
            sticky_p0   <= '0;
        end else begin
            vld_p0    <= load;
            sticky_p0 <= sticky_p0 | ovf | unf;
            if (load) begin
                p_p0        <= bus.S;
                carry_p0    <= bus.result_SIDM_carry_out;
                pd_p0       <= pd_next;
                pbd_p0      <= pbd_next;
                pd_past_p0  <= pd_p0;
                pbd_past_p0 <= pbd_p0;
            end
        end
    end

    assign bus.P              = p_p0;
    assign bus.valid_out      = vld_p0;
    assign bus.CARRYOUT       = carry_p0;
    assign bus.PATTERNDETECT  = pd_p0;
    assign bus.PATTERNBDETECT = pbd_p0;
    assign bus.OVERFLOW       = ovf;
    assign bus.UNDERFLOW      = unf;
    assign bus.OVF_STICKY     = sticky_p0;

endmodule

// File: tb/tb_p_stage_accum_20bits.sv
// Directed bench for p_stage_accum_20bits with hand-computed expectations.
module tb_p_stage_accum_20bits;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_pass;

    p_stage_accum_20bits_if bus ();

    p_stage_accum_20bits dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_all(
        input string       tag,
        input logic [19:0] p,
        input logic        vo,
        input logic [1:0]  co,
        input logic [1:0]  pd,
        input logic [1:0]  pbd,
        input logic [1:0]  ov,
        input logic [1:0]  un,
        input logic [1:0]  st
    );
        check({tag, ".P"},              32'(bus.P),              32'(p));
        check({tag, ".valid_out"},      32'(bus.valid_out),      32'(vo));
        check({tag, ".CARRYOUT"},       32'(bus.CARRYOUT),       32'(co));
        check({tag, ".PATTERNDETECT"},  32'(bus.PATTERNDETECT),  32'(pd));
        check({tag, ".PATTERNBDETECT"}, 32'(bus.PATTERNBDETECT), 32'(pbd));
        check({tag, ".OVERFLOW"},       32'(bus.OVERFLOW),       32'(ov));
        check({tag, ".UNDERFLOW"},      32'(bus.UNDERFLOW),      32'(un));
        check({tag, ".OVF_STICKY"},     32'(bus.OVF_STICKY),     32'(st));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rstn                      = 1'b1;
        bus.CEP                   = 1'b1;
        bus.RSTP                  = 1'b0;
        bus.valid_in              = 1'b1;
        bus.USE_SIMD              = 2'b00;
        bus.S                     = 20'hABCDE;
        bus.result_SIDM_carry_out = 2'b00;
        bus.PATTERN               = 20'h00000;
        bus.MASK                  = 20'h00000;
        #1 rstn = 1'b0;
        #2;
        check_all("rst_async", 20'h0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        step();
        step();
        check_all("rst_held", 20'h0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        @(negedge clk);
        rstn = 1'b1;
        step();
        check_all("rst_release", 20'hABCDE, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        // CEP gating
        bus.S = 20'h12345;
        step();
        check("cep_load.P", 32'(bus.P), 32'h12345);
        bus.CEP = 1'b0;
        bus.S   = 20'h54321;
        for (int i = 0; i < 3; i++) begin
            step();
            check("cep_hold.P",         32'(bus.P),         32'h12345);
            check("cep_hold.valid_out", 32'(bus.valid_out), 32'h0);
        end

        // Overflow, single lane
        bus.CEP     = 1'b1;
        bus.PATTERN = 20'h00000;
        bus.MASK    = 20'h0FFFF;
        bus.S       = 20'h0FFFF;
        step();
        check_all("ovf_a", 20'h0FFFF, 1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        bus.S = 20'h10000;
        step();
        check_all("ovf_b", 20'h10000, 1'b1, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        bus.valid_in = 1'b0;
        step();
        check_all("ovf_sticky", 20'h10000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11);

        // Underflow, single lane
        bus.valid_in = 1'b1;
        bus.S        = 20'hF0000;
        step();
        check_all("unf_a", 20'hF0000, 1'b1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11);
        bus.S = 20'hE0000;
        step();
        check_all("unf_b", 20'hE0000, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11);

        // SIMD two-lane mode
        bus.USE_SIMD = 2'b10;
        bus.MASK     = 20'h00FFF;
        bus.S        = 20'h40ABC;
        step();
        check_all("simd_a", 20'h40ABC, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11);
        bus.S                     = 20'h41ABC;
        bus.result_SIDM_carry_out = 2'b10;
        step();
        check_all("simd_b", 20'h41ABC, 1'b1, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b11);

        // RSTP overrides a concurrent load
        bus.RSTP = 1'b1;
        bus.S    = 20'hFFFFF;
        step();
        check_all("rstp", 20'h0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        bus.RSTP     = 1'b0;
        bus.valid_in = 1'b0;
        step();
        check_all("rstp_after", 20'h0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
